// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  localparam int unsigned ByteWidth = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_t;

  typedef enum logic {
    SRC_BTN  = 1'b0,
    SRC_ECHO = 1'b1
  } src_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Request/transmit handshake bundle between the byte sources, the TX core and the arbiter.
interface uart_tx_arbiter_if;
  import uart_pkg::*;

  logic                 btn_req;
  logic [ByteWidth-1:0] btn_data;
  logic                 rx_valid;
  logic [ByteWidth-1:0] rx_data;
  logic                 tx_busy;
  logic                 tx_start;
  logic [ByteWidth-1:0] tx_data;
  logic                 grant_src;
  logic                 arb_busy;
  logic [7:0]           drop_cnt;
  logic                 timeout_err;

  // Environment side: sources and transmitter.
  modport master (
    output btn_req, btn_data, rx_valid, rx_data, tx_busy,
    input  tx_start, tx_data, grant_src, arb_busy, drop_cnt, timeout_err
  );

  // Arbiter side.
  modport slave (
    input  btn_req, btn_data, rx_valid, rx_data, tx_busy,
    output tx_start, tx_data, grant_src, arb_busy, drop_cnt, timeout_err
  );

endinterface

// File: rtl/req_holder.sv
// One-entry holding register for a byte source: data plus pending flag.
module req_holder
  import uart_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic [ByteWidth-1:0] req_data,
  input  logic                 clr,
  output logic                 pending,
  output logic [ByteWidth-1:0] data,
  output logic                 drop
);

  logic set;

  // A clear in the same cycle frees the slot, so the new request is accepted.
  assign set  = req && (!pending || clr);
  assign drop = req && pending && !clr;

  // Capture on accept; set has priority over clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
      data    <= '0;
    end else if (set) begin
      pending <= 1'b1;
      data    <= req_data;
    end else if (clr) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between the button and echo byte sources.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input logic               clk,
  input logic               reset,
  uart_tx_arbiter_if.slave  bus
);

  localparam int unsigned CntWidth = $clog2(BUSY_TIMEOUT + 1);

  arb_state_t           state_q;
  src_t                 ptr_q;
  src_t                 grant_q;
  src_t                 win;
  logic                 tx_start_q;
  logic                 timeout_q;
  logic [ByteWidth-1:0] tx_data_q;
  logic [CntWidth-1:0]  cnt_q;
  logic [7:0]           drop_q;
  logic [8:0]           drop_sum;

  logic                 pend_btn, pend_echo;
  logic                 drop_btn, drop_echo;
  logic                 clr_btn, clr_echo;
  logic [ByteWidth-1:0] data_btn, data_echo;

  // The winner's slot is freed while its frame is being launched.
  assign clr_btn  = (state_q == LAUNCH) && (grant_q == SRC_BTN);
  assign clr_echo = (state_q == LAUNCH) && (grant_q == SRC_ECHO);

  req_holder u_btn_holder (
    .clk      (clk),
    .reset    (reset),
    .req      (bus.btn_req),
    .req_data (bus.btn_data),
    .clr      (clr_btn),
    .pending  (pend_btn),
    .data     (data_btn),
    .drop     (drop_btn)
  );

  req_holder u_echo_holder (
    .clk      (clk),
    .reset    (reset),
    .req      (bus.rx_valid),
    .req_data (bus.rx_data),
    .clr      (clr_echo),
    .pending  (pend_echo),
    .data     (data_echo),
    .drop     (drop_echo)
  );

  // Pick the winner: lone pending source, else the one the pointer favours.
  always_comb begin
    win = SRC_BTN;
    if (pend_btn && pend_echo) begin
      win = ptr_q;
    end else if (pend_echo) begin
      win = SRC_ECHO;
    end
  end

  // Sequencer: launch, wait for busy to rise (with timeout), wait for busy to fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= SRC_BTN;
      grant_q    <= SRC_BTN;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if ((pend_btn || pend_echo) && !bus.tx_busy) begin
            state_q    <= LAUNCH;
            tx_start_q <= 1'b1;
            grant_q    <= win;
            tx_data_q  <= (win == SRC_ECHO) ? data_echo : data_btn;
            ptr_q      <= (win == SRC_BTN) ? SRC_ECHO : SRC_BTN;
          end
        end
        LAUNCH: begin
          state_q <= WAIT_BUSY;
          cnt_q   <= '0;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state_q <= WAIT_DONE;
          end else if (cnt_q == CntWidth'(BUSY_TIMEOUT - 1)) begin
            // Transmitter never answered: give up on this byte.
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign drop_sum = {1'b0, drop_q} + {8'd0, drop_btn} + {8'd0, drop_echo};

  // Saturating drop counter; both sources may drop in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
    end else if (drop_sum > 9'd255) begin
      drop_q <= 8'hFF;
    end else begin
      drop_q <= drop_sum[7:0];
    end
  end

  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.grant_src   = grant_q;
  assign bus.arb_busy    = (state_q != IDLE);
  assign bus.drop_cnt    = drop_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple transmitter model.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic reset;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(
    .BUSY_TIMEOUT (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Transmitter model: busy rises the cycle after tx_start and holds busy_len cycles.
  logic model_en;
  logic busy_force;
  int   busy_len;
  int   busy_left;

  always @(posedge clk) begin
    if (reset) begin
      busy_left <= 0;
    end else if (bus.tx_start) begin
      busy_left <= busy_len;
    end else if (busy_left != 0) begin
      busy_left <= busy_left - 1;
    end
  end

  assign bus.tx_busy = model_en ? (busy_left != 0) : busy_force;

  // Frame log: {grant_src, tx_data} for every tx_start pulse.
  logic [8:0] log_q[$];

  always @(negedge clk) begin
    if (bus.tx_start === 1'b1) log_q.push_back({bus.grant_src, bus.tx_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    bus.btn_req  = 1'b0;
    bus.rx_valid = 1'b0;
    reset = 1'b1;
    tick(2);
    log_q.delete();
    reset = 1'b0;
  endtask

  task automatic wait_tx_busy(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      seen = bus.tx_busy;
    end
    check(tag, seen, 1'b1);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_tx_start"}, bus.tx_start, 0);
    check({pfx, "_tx_data"}, bus.tx_data, 0);
    check({pfx, "_grant_src"}, bus.grant_src, 0);
    check({pfx, "_arb_busy"}, bus.arb_busy, 0);
    check({pfx, "_drop_cnt"}, bus.drop_cnt, 0);
    check({pfx, "_timeout_err"}, bus.timeout_err, 0);
  endtask

  initial begin
    bus.btn_req  = 1'b0;
    bus.btn_data = 8'h00;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    model_en     = 1'b1;
    busy_force   = 1'b0;
    busy_len     = 10;
    reset        = 1'b1;
    tick(2);
    check_all_zero("rst");
    reset = 1'b0;

    // Single button send: start two cycles after the request, busy for 10 cycles.
    bus.btn_data = 8'hA5;
    bus.btn_req  = 1'b1;
    tick(1);
    bus.btn_req = 1'b0;
    check("t1_no_early_start", bus.tx_start, 0);
    tick(1);
    check("t1_start", bus.tx_start, 1);
    check("t1_data", bus.tx_data, 8'hA5);
    check("t1_grant", bus.grant_src, 0);
    check("t1_arb_busy", bus.arb_busy, 1);
    tick(11);
    check("t1_busy_held", bus.arb_busy, 1);
    tick(1);
    check("t1_idle", bus.arb_busy, 0);
    check("t1_frames", log_q.size(), 1);

    // Simultaneous requests: button first after reset, then echo.
    do_reset();
    bus.btn_data = 8'h11;
    bus.rx_data  = 8'h22;
    bus.btn_req  = 1'b1;
    bus.rx_valid = 1'b1;
    tick(1);
    bus.btn_req  = 1'b0;
    bus.rx_valid = 1'b0;
    tick(60);
    check("t2_frames", log_q.size(), 2);
    check("t2_first", log_q[0], {1'b0, 8'h11});
    check("t2_second", log_q[1], {1'b1, 8'h22});

    // Overflow: three echo bytes while a button frame is on the wire.
    do_reset();
    bus.btn_data = 8'h77;
    bus.btn_req  = 1'b1;
    tick(1);
    bus.btn_req = 1'b0;
    wait_tx_busy("t3_busy_seen");
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h01;
    tick(1);
    bus.rx_data = 8'h02;
    tick(1);
    bus.rx_data = 8'h03;
    tick(1);
    bus.rx_valid = 1'b0;
    check("t3_drop_cnt", bus.drop_cnt, 2);
    tick(60);
    check("t3_frames", log_q.size(), 2);
    check("t3_btn_frame", log_q[0], {1'b0, 8'h77});
    check("t3_echo_frame", log_q[1], {1'b1, 8'h01});
    check("t3_drop_final", bus.drop_cnt, 2);

    // Saturation: busy transmitter blocks launch; double drops, then 300 echo drops.
    do_reset();
    model_en     = 1'b0;
    busy_force   = 1'b1;
    bus.btn_data = 8'hC1;
    bus.rx_data  = 8'hC2;
    bus.btn_req  = 1'b1;
    bus.rx_valid = 1'b1;
    tick(1);
    check("sat_capture", bus.drop_cnt, 0);
    tick(127);
    check("sat_double_254", bus.drop_cnt, 254);
    tick(1);
    check("sat_double_255", bus.drop_cnt, 255);
    bus.btn_req = 1'b0;
    tick(300);
    bus.rx_valid = 1'b0;
    check("sat_300_drops", bus.drop_cnt, 255);
    check("sat_no_launch", log_q.size(), 0);
    check("sat_idle", bus.arb_busy, 0);

    // Timeout: transmitter never goes busy.
    busy_force = 1'b0;
    do_reset();
    bus.btn_data = 8'h5A;
    bus.btn_req  = 1'b1;
    tick(1);
    bus.btn_req = 1'b0;
    tick(1);
    check("to_start", bus.tx_start, 1);
    check("to_data", bus.tx_data, 8'h5A);
    tick(16);
    check("to_not_yet", bus.timeout_err, 0);
    check("to_still_waiting", bus.arb_busy, 1);
    tick(1);
    check("to_err", bus.timeout_err, 1);
    check("to_idle", bus.arb_busy, 0);
    tick(40);
    check("to_no_retry", log_q.size(), 1);
    check("to_sticky", bus.timeout_err, 1);

    // Reset mid-frame with an echo byte pending.
    model_en = 1'b1;
    busy_len = 20;
    do_reset();
    bus.btn_data = 8'h33;
    bus.btn_req  = 1'b1;
    tick(1);
    bus.btn_req = 1'b0;
    wait_tx_busy("mid_busy_seen");
    tick(2);
    bus.rx_data  = 8'h44;
    bus.rx_valid = 1'b1;
    tick(1);
    bus.rx_valid = 1'b0;
    check("mid_in_frame", bus.arb_busy, 1);
    reset = 1'b1;
    tick(1);
    check_all_zero("mid_rst");
    reset = 1'b0;
    log_q.delete();
    tick(40);
    check("mid_no_start", log_q.size(), 0);

    // Fairness: both sources re-requesting continuously.
    busy_len = 3;
    do_reset();
    bus.btn_data = 8'hB0;
    bus.rx_data  = 8'hE0;
    bus.btn_req  = 1'b1;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 400 && log_q.size() < 6; i++) tick(1);
    bus.btn_req  = 1'b0;
    bus.rx_valid = 1'b0;
    check("fair_frames", log_q.size() >= 6, 1);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("fair_frame%0d", i), log_q[i],
            (i % 2 == 0) ? {1'b0, 8'hB0} : {1'b1, 8'hE0});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
